button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Upstream input stage for the LED rotator.
- Takes the raw push-button level, synchronises and debounces it, and drives the rotator's `button` enable with a clean level.
- Also produces press/release strobes, a hold-to-repeat strobe and a wrapping press counter for status logic.
- Fully synchronous to the rotator's clock.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles synchronised input must differ from stable level before accepted (>=1)
- REPEAT_DELAY, 16, cycles from press_pulse to first repeat_pulse; 0 disables repeat
- REPEAT_PERIOD, 4, cycles between subsequent repeat_pulses (>=1)
- RST_LEVEL, 1, reset value of stable level and both synchroniser flops

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- button_raw  input  1  asynchronous raw button level, 1 = pressed/go
- button  output  1  debounced stable level (feeds rotator enable)
- press_pulse  output  1  one-cycle strobe on stable 0->1
- release_pulse  output  1  one-cycle strobe on stable 1->0
- repeat_pulse  output  1  one-cycle strobe while held (auto-repeat)
- press_count  output  8  count of press_pulse events, wraps 255->0

Behaviour:
- One clock; reset is synchronous and active-high. All state updates only on rising clk. rst sampled high forces at that edge:
  - sync1 = sync2 = button = RST_LEVEL
  - debounce counter 0, repeat counter 0, FSM IDLE
  - press_pulse = release_pulse = repeat_pulse = 0, press_count = 0
- Reset applies mid-operation too, overriding any pending debounce/repeat. No pulse is generated by the reset itself, even if button_raw differs from RST_LEVEL.
- Synchroniser: two flops, sync1 <= button_raw, sync2 <= sync1.
- Debounce:
  - if sync2 == button: counter <= 0
  - else if counter == DEBOUNCE_CYCLES-1: button <= sync2, counter <= 0
  - else: counter <= counter+1
- Latency: a held raw change appears on button at the (DEBOUNCE_CYCLES+2)th rising edge sampling the new raw level, counting that first edge as 1. With defaults this is the 6th edge.
- Glitches: any excursion shorter than DEBOUNCE_CYCLES cycles at sync2 is ignored and the counter is cleared when it ends. An excursion of exactly DEBOUNCE_CYCLES is accepted.
- Strobes:
  - press_pulse and release_pulse are registered and asserted for exactly the one cycle following the edge where button changes.
  - press_count increments at that same edge; 8-bit modular.
- Repeat FSM, counter width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1):
  - IDLE: on the edge where button rises, if REPEAT_DELAY != 0, go to DELAY with rcnt = 1; else stay IDLE.
  - DELAY: if button falls this edge, go to IDLE. Else if rcnt == REPEAT_DELAY, assert repeat_pulse, go to RPT with rcnt = 1. Else rcnt++.
  - RPT: if button falls, go to IDLE. Else if rcnt == REPEAT_PERIOD, assert repeat_pulse, rcnt = 1. Else rcnt++.
- Repeat timing: if press_pulse is high in cycle t, repeat_pulse is high in cycles t+REPEAT_DELAY, then +REPEAT_PERIOD each time after.
- Release on the same edge a repeat would fire suppresses that repeat. repeat_pulse is never high in the same cycle as release_pulse.
- A stable level of 1 out of reset (RST_LEVEL=1) does not arm the repeat. Only a press_pulse arms it.
- Outputs never X after the first reset edge. press_pulse, release_pulse and repeat_pulse are mutually exclusive, except press_pulse cannot coincide with repeat_pulse by construction.

Test Plan (defaults):
- rst=1 for 2 edges, button_raw=1 -> button=1, all pulses 0, press_count=0; no release_pulse after deassert while raw stays 1.
- From stable 1, drive raw=0 held -> button falls at 6th edge; release_pulse high exactly 1 cycle; press_count unchanged; rotator enable drops.
- From stable 1:
  - raw=0 for 3 cycles then 1 -> button stays 1, no pulses.
  - Repeat with raw=0 for 4 cycles -> button falls, then rises again after raw returns, with release_pulse then press_pulse.
- From stable 0, raw=1 held 40 cycles:
  - press_pulse at cycle t; repeat_pulse at t+16, t+20, t+24, t+28, ...; press_count=1.
  - Then raw=0 -> release_pulse, repeats stop.
- Release timed so button falls at the edge of a scheduled repeat -> release_pulse only, no repeat_pulse that cycle.
- 256 clean press/release cycles -> press_count wraps to 0.
- rst asserted mid-RPT with raw=1 -> next edge: button=1, press_count=0, no pulses; no repeat_pulse until a new press_pulse.

Source files
------------

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - push-button synchroniser, debouncer, edge strobes, press counter and auto-repeat
module button_conditioner #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter int   REPEAT_DELAY    = 16,
  parameter int   REPEAT_PERIOD   = 4,
  parameter logic RST_LEVEL       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_raw,
  output logic       button,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic [7:0] press_count
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // Repeat counter must hold the larger of delay and period.
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPER = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] RONE = RW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } state_t;

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] dcnt;
  logic          differs;
  logic          accept;
  logic          rise;
  logic          fall;
  state_t        state;
  logic [RW-1:0] rcnt;

  // Two-flop synchroniser for the asynchronous raw level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= RST_LEVEL;
      sync2 <= RST_LEVEL;
    end else begin
      sync1 <= button_raw;
      sync2 <= sync1;
    end
  end

  // A change is accepted on the edge that completes DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    differs = (sync2 != button);
    accept  = differs && (dcnt == DCNT_LAST);
    rise    = accept && sync2;
    fall    = accept && !sync2;
  end

  // Debouncer: any sample agreeing with the stable level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      button <= RST_LEVEL;
      dcnt   <= '0;
    end else if (!differs) begin
      dcnt   <= '0;
    end else if (accept) begin
      button <= sync2;
      dcnt   <= '0;
    end else begin
      dcnt   <= dcnt + 1'b1;
    end
  end

  // Registered press/release strobes and the wrapping press counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      press_pulse   <= rise;
      release_pulse <= fall;
      if (rise) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

  // Auto-repeat FSM: armed only by an accepted press, a release always wins over a due repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rcnt         <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (rise && (REPEAT_DELAY != 0)) begin
            state <= DELAY;
            rcnt  <= RONE;
          end
        end
        DELAY: begin
          if (fall) begin
            state <= IDLE;
            rcnt  <= '0;
          end else if (rcnt == RDLY) begin
            repeat_pulse <= 1'b1;
            state        <= RPT;
            rcnt         <= RONE;
          end else begin
            rcnt <= rcnt + RONE;
          end
        end
        RPT: begin
          if (fall) begin
            state <= IDLE;
            rcnt  <= '0;
          end else if (rcnt == RPER) begin
            repeat_pulse <= 1'b1;
            rcnt         <= RONE;
          end else begin
            rcnt <= rcnt + RONE;
          end
        end
        default: begin
          state <= IDLE;
          rcnt  <= '0;
        end
      endcase
    end
  end

endmodule
